// File: rtl/light_req_cond_pkg.sv
// Shared types and constants for the tail-light request conditioner.
// Holds the conditioner FSM encoding, the FSM-idle code and request bit indices.
package light_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } cond_state_t;

  localparam logic [3:0] Y_IDLE = 4'b0000;

  localparam int REQ_LEFT  = 0;
  localparam int REQ_RIGHT = 1;
  localparam int REQ_HAZ   = 2;

  // One-hot pick with hazard > right > left, mirroring the light FSM's c > b > a.
  function automatic logic [2:0] prio_sel(input logic [2:0] pend);
    logic [2:0] r;
    r = 3'b000;
    if (pend[REQ_HAZ])        r[REQ_HAZ]   = 1'b1;
    else if (pend[REQ_RIGHT]) r[REQ_RIGHT] = 1'b1;
    else if (pend[REQ_LEFT])  r[REQ_LEFT]  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/light_req_cond_sw_debounce.sv
// Two-flop synchroniser, counter debouncer and rising-edge press pulse for one switch.
// Switch edge to press pulse is 2 + DB_CYCLES cycles; no backpressure.
module sw_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            lvl_q, lvl_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the debounced level restarts the stability count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) lvl_d = ~lvl_q;
      else                   cnt_d = cnt_q + DB_W'(1);
    end
    press_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= sw_i;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = lvl_q;
  assign press_o = press_q;

endmodule

// File: rtl/light_req_cond.sv
// Latches debounced switch presses and hands them to the light FSM one at a time while it is idle.
// Optional LIGHT_REQ_AUTOREPEAT_EN: a still-held switch re-arms its request when a sequence ends.
module light_req_cond
  import light_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int DB_W        = 8,
  parameter int ACK_TIMEOUT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_haz,
  input  logic [3:0] y_fsm,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] pending
);

  localparam int             TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);

  logic [2:0] sw_raw, level, press;

  assign sw_raw = {sw_haz, sw_right, sw_left};

  for (genvar i = 0; i < 3; i++) begin : g_sw
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .sw_i   (sw_raw[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  cond_state_t      state_q, state_d;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       req_q, req_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       set_v, clr_v;

`ifndef LIGHT_REQ_AUTOREPEAT_EN
  logic unused_level;
  assign unused_level = ^level;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    req_d   = 3'b000;
    set_v   = press;
    clr_v   = 3'b000;
    case (state_q)
      IDLE: begin
        if (y_fsm == Y_IDLE && pending_q != 3'b000) begin
          state_d = ISSUE;
          sel_d   = prio_sel(pending_q);
          req_d   = sel_d;
        end
      end
      ISSUE: begin
        clr_v   = sel_q;
        tmo_d   = TMO_LOAD;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // No acknowledgement in time: put the request back and retry from IDLE.
        if (y_fsm != Y_IDLE) begin
          state_d = WAIT_IDLE;
        end else if (tmo_q == '0) begin
          set_v   = set_v | sel_q;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (y_fsm == Y_IDLE) begin
          state_d = IDLE;
`ifdef LIGHT_REQ_AUTOREPEAT_EN
          set_v = set_v | level;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // A set landing on the same cycle as the clear keeps the bit.
    pending_d = (pending_q & ~clr_v) | set_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 3'b000;
      sel_q     <= 3'b000;
      req_q     <= 3'b000;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      req_q     <= req_d;
      tmo_q     <= tmo_d;
    end
  end

  assign a       = req_q[REQ_LEFT];
  assign b       = req_q[REQ_RIGHT];
  assign c       = req_q[REQ_HAZ];
  assign pending = pending_q;

endmodule

// File: tb/tb_light_req_cond.sv
// Directed bench for light_req_cond: expected pulses are queued by the stimulus and
// popped by a negedge monitor; a small light-FSM model acknowledges issued requests.
module tb_light_req_cond;

  logic       clk;
  logic       reset;
  logic       sw_left, sw_right, sw_haz;
  logic [3:0] y_fsm;
  logic       a, b, c;
  logic [2:0] pending;

  light_req_cond dut (
    .clk     (clk),
    .reset   (reset),
    .sw_left (sw_left),
    .sw_right(sw_right),
    .sw_haz  (sw_haz),
    .y_fsm   (y_fsm),
    .a       (a),
    .b       (b),
    .c       (c),
    .pending (pending)
  );

  typedef struct {
    logic [2:0] req;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 0;
  bit   ack_en = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Light FSM stand-in: after a request pulse, walk 7 -> 8 -> 9 -> 0.
  initial begin
    int seq;
    bit seen;
    seq   = 0;
    y_fsm = 4'd0;
    forever begin
      @(negedge clk);
      seen = (a | b | c) && !reset;
      @(posedge clk);
      #1;
      if (seq != 0) begin
        seq   = seq - 1;
        y_fsm = (seq == 2) ? 4'd8 : (seq == 1) ? 4'd9 : 4'd0;
      end else if (seen && ack_en) begin
        seq   = 3;
        y_fsm = 4'd7;
      end
    end
  end

  // Every pulse on a/b/c must match the head of the expectation queue.
  always @(negedge clk) begin
    logic [2:0] got;
    exp_t       e;
    got = {c, b, a};
    if (mon_en && got != 3'b000) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected: got cba=%b at cycle %0d, required no pulse", got, cyc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e.req || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL pulse_match: got cba=%b at cycle %0d, required cba=%b at cycle %0d",
                   got, cyc, e.req, e.cyc);
        end
      end
    end
  end

  task automatic at_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b at cycle %0d, required %b", nm, act, cyc, req);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] req, input int t);
    exp_t e;
    e.req = req;
    e.cyc = t;
    exp_q.push_back(e);
  endtask

  initial begin
    int k, n;
    reset    = 1'b1;
    sw_left  = 1'b0;
    sw_right = 1'b0;
    sw_haz   = 1'b0;

    at_cyc(2);
    reset  = 1'b0;
    mon_en = 1'b1;
    chk3("reset_cba", {c, b, a}, 3'b000);
    chk3("reset_pending", pending, 3'b000);

    // Quiet switches: nothing latched, nothing issued.
    for (int t = 5; t <= 20; t += 5) begin
      at_cyc(t);
      chk3("quiet_pending", pending, 3'b000);
    end

    // Single left press.
    k = 25;
    at_cyc(k);     sw_left = 1'b1; expect_pulse(3'b001, k + 8);
    at_cyc(k + 5); sw_left = 1'b0;
    at_cyc(k + 7); chk3("left_pending_set", pending, 3'b001);
    at_cyc(k + 9); chk3("left_pending_clr", pending, 3'b000);

    // Left and hazard together: hazard first, left after the sequence plus one idle cycle.
    k = 60;
    at_cyc(k);
    sw_left = 1'b1;
    sw_haz  = 1'b1;
    expect_pulse(3'b100, k + 8);
    expect_pulse(3'b001, k + 14);
    at_cyc(k + 5);  sw_left = 1'b0; sw_haz = 1'b0;
    at_cyc(k + 7);  chk3("dual_pending_set", pending, 3'b101);
    at_cyc(k + 9);  chk3("dual_pending_left", pending, 3'b001);
    at_cyc(k + 15); chk3("dual_pending_clr", pending, 3'b000);

    // Right switch bouncing before settling: one request only.
    k = 100;
    at_cyc(k);     sw_right = 1'b1;
    at_cyc(k + 1); sw_right = 1'b0;
    at_cyc(k + 2); sw_right = 1'b1; expect_pulse(3'b010, k + 10);
    at_cyc(k + 7); sw_right = 1'b0;
    at_cyc(k + 8); chk3("bounce_pending_quiet", pending, 3'b000);
    at_cyc(k + 9); chk3("bounce_pending_set", pending, 3'b010);

    // No acknowledgement: retry, then reset in the middle of the acknowledged sequence.
    k = 140;
    n = k + 8;
    at_cyc(k);
    ack_en  = 1'b0;
    sw_left = 1'b1;
    expect_pulse(3'b001, n);
    expect_pulse(3'b001, n + 4);
    at_cyc(k + 5); sw_left = 1'b0;
    at_cyc(n);     sw_haz = 1'b1;
    at_cyc(n + 1); chk3("retry_pending_clr", pending, 3'b000);
    at_cyc(n + 2); ack_en = 1'b1;
    at_cyc(n + 3); chk3("retry_pending_restore", pending, 3'b001);
    at_cyc(n + 7);
    chk3("midseq_pending_haz", pending, 3'b100);
    reset  = 1'b1;
    sw_haz = 1'b0;
    at_cyc(n + 8);
    reset = 1'b0;
    chk3("midseq_reset_pending", pending, 3'b000);
    chk3("midseq_reset_cba", {c, b, a}, 3'b000);
    at_cyc(n + 14); chk3("post_reset_pending", pending, 3'b000);

    // Held hazard switch.
    k = 180;
    n = k + 8;
    at_cyc(k);
    sw_haz = 1'b1;
    expect_pulse(3'b100, n);
`ifdef LIGHT_REQ_AUTOREPEAT_EN
    expect_pulse(3'b100, n + 6);
    expect_pulse(3'b100, n + 12);
`endif
    at_cyc(n + 7); sw_haz = 1'b0;
    at_cyc(n + 40);
    chk3("final_pending", pending, 3'b000);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL pulse_missing: got no pulse, required cba=%b at cycle %0d", e.req, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/light_req_cond.md
Name: light_req_cond

Overview:
- Input conditioner sitting directly upstream of the tail-light sequencing FSM.
- Synchronises and debounces three raw switches (left, right, hazard) and latches their press events.
- Issues exactly one single-cycle request on a/b/c, and only while the light FSM reports idle (y == 4'b0000).
- Prevents lost or overlapping requests while a 3-step light sequence is running.

Parameters:
- DB_CYCLES, 4: consecutive stable cycles required before a debounced level changes (legal range 1..255).
- DB_W, 8: width of the debounce counter; must hold DB_CYCLES.
- ACK_TIMEOUT, 2: cycles to wait for the FSM to leave idle after an issue before retrying.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sw_left  in  1  raw asynchronous left switch
- sw_right  in  1  raw asynchronous right switch
- sw_haz  in  1  raw asynchronous hazard switch
- y_fsm  in  4  state output of the light FSM; 4'b0000 means idle
- a  out  1  left request pulse to the light FSM (registered)
- b  out  1  right request pulse (registered)
- c  out  1  hazard request pulse (registered)
- pending  out  3  latched requests, {haz,right,left} (registered)

Behaviour:
- Reset is synchronous: a=b=c=0, pending=3'b000, sync flops=0, debounced levels=0, debounce counters=0, FSM in IDLE, timeout counter=0.
- Per switch: a 2-flop synchroniser, then the debouncer.
  - The counter increments while the synced value differs from the debounced level; it clears when they match.
  - When the counter reaches DB_CYCLES-1 and the values still differ, the debounced level toggles and the counter clears.
  - A rising edge on the debounced level produces a 1-cycle press pulse.
  - Latency from a clean switch edge to the press pulse is 2 + DB_CYCLES cycles.
- A press pulse sets the corresponding pending bit. Falling edges are ignored.
- Conditioner FSM:
  - IDLE: if y_fsm == 0 and pending != 0, go to ISSUE. Select the highest-priority bit: haz > right > left, matching the light FSM's c > b > a priority.
  - ISSUE (1 cycle): assert exactly one of c/b/a for this cycle only. Clear the selected pending bit. Load the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY: if y_fsm != 0, go to WAIT_IDLE. Otherwise decrement the timeout. On expiry, re-set the issued pending bit and return to IDLE (retry).
  - WAIT_IDLE: stay until y_fsm == 0, then go to IDLE. Re-issue is possible 1 cycle later, so there is at least 1 idle cycle between sequences.
- a/b/c are never asserted together and never asserted outside ISSUE.
- Simultaneous set and clear of the same pending bit in one cycle: set wins, and the bit stays 1.
- Multiple presses of the same switch during a sequence collapse into one pending request.
- Reset mid-sequence drops all pending requests and returns to IDLE; no pulse is emitted during the reset cycle.
- If y_fsm is non-zero while in IDLE (FSM not idle), requests are held indefinitely.

Optional Feature:
- Macro: LIGHT_REQ_AUTOREPEAT_EN.
- Defined: on entry to IDLE from WAIT_IDLE, any switch whose debounced level is still 1 re-sets its pending bit. A held switch therefore repeats its sequence back-to-back, still with the 1-cycle idle gap and the normal priority.
- Undefined: only debounced rising edges set pending. A held switch produces exactly one sequence.

Decomposition:
- Package light_pkg holds:
  - the enum cond_state_t {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE}
  - the constant Y_IDLE = 4'b0000
  - the request index constants REQ_LEFT=0, REQ_RIGHT=1, REQ_HAZ=2
- One sub-module, sw_debounce (synchroniser + debouncer + rise-pulse, parameterised by DB_CYCLES/DB_W), instantiated three times.

Test Plan:
- Reset, then hold all switches 0 for 20 cycles -> a=b=c=0 and pending=000 throughout.
- Clean sw_left rise, y_fsm=0 -> press pulse at cycle 6; pending=001 at cycle 7; a=1 for exactly 1 cycle at cycle 8; pending=000 afterwards.
- sw_left and sw_haz rise in the same cycle, with y_fsm following S0→7→8→9→0 after the c pulse -> c issued first; a issued only after y_fsm returns to 0 plus 1 cycle.
- sw_right bounces 1/0/1/0 every cycle for 3 cycles, then is stable 1 (DB_CYCLES=4) -> exactly one b pulse; no pulse during the bounce.
- Issue a with y_fsm held at 0 for 2 cycles (no ack) -> pending bit restored, a re-pulsed at the next IDLE→ISSUE; then assert reset mid-WAIT_IDLE -> pending=000, no further pulses.
- With LIGHT_REQ_AUTOREPEAT_EN, hold sw_haz high across three sequences -> three c pulses, each 1 cycle after y_fsm returns to 0. Without the macro -> exactly one c pulse.
